// File: rtl/arc4_ctrl.sv
// arc4_ctrl: sequences init/ksa/prga sub-blocks, arbitrates the S-memory port, aborts stalled phases
module arc4_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [23:0] key_q,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_wrdata,
  input  logic        init_wren,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_wrdata,
  input  logic        ksa_wren,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_wrdata,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  output logic [1:0]  phase,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, INIT_GO, INIT_BUSY, KSA_GO, KSA_BUSY, PRGA_GO, PRGA_BUSY} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic go, go_n, sub_rdy, guard, to;
  always_comb begin
    go      = state == INIT_GO || state == KSA_GO || state == PRGA_GO;
    go_n    = state_n == INIT_GO || state_n == KSA_GO || state_n == PRGA_GO;
    phase   = state == IDLE ? 2'd0 : state <= INIT_BUSY ? 2'd1 : state <= KSA_BUSY ? 2'd2 : 2'd3;
    sub_rdy = phase == 2'd1 ? init_rdy : phase == 2'd2 ? ksa_rdy : prga_rdy;
    // X_en is high exactly in the first BUSY cycle, so it doubles as the guard flag
    guard   = init_en | ksa_en | prga_en;
    to      = state != IDLE && cnt >= TIMEOUT;
    rdy     = state == IDLE;
    s_addr   = phase == 2'd1 ? init_addr   : phase == 2'd2 ? ksa_addr   : phase == 2'd3 ? prga_addr   : 8'd0;
    s_wrdata = phase == 2'd1 ? init_wrdata : phase == 2'd2 ? ksa_wrdata : phase == 2'd3 ? prga_wrdata : 8'd0;
    s_wren   = phase == 2'd1 ? init_wren   : phase == 2'd2 ? ksa_wren   : phase == 2'd3 && prga_wren;
    state_n = state;
    if (state == IDLE)
      state_n = en ? INIT_GO : IDLE;
    else if (to)
      state_n = IDLE;
    else if (sub_rdy && (go || !guard))
      state_n = state == PRGA_BUSY ? IDLE : state_t'(state + 3'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key_q   <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      init_en <= 1'b0;
      ksa_en  <= 1'b0;
      prga_en <= 1'b0;
    end else begin
      state   <= state_n;
      init_en <= state == INIT_GO && state_n == INIT_BUSY;
      ksa_en  <= state == KSA_GO && state_n == KSA_BUSY;
      prga_en <= state == PRGA_GO && state_n == PRGA_BUSY;
      cnt     <= go_n && state_n != state ? 16'd0 : state != IDLE && cnt != 16'hFFFF ? cnt + 16'd1 : cnt;
      if (state == IDLE && en) begin
        key_q <= key;
        err   <= 1'b0;
      end else if (to)
        err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: directed checks of sequencing, arbitration, timeout and reset for arc4_ctrl
module tb_arc4_ctrl;
  logic clk = 1'b0;
  logic rst, en, en_t;
  logic [23:0] key;
  logic init_rdy, ksa_rdy, prga_rdy, t_init_rdy, t_ksa_rdy, t_prga_rdy;
  logic [7:0] init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic init_wren, ksa_wren, prga_wren;
  logic rdy, init_en, ksa_en, prga_en, s_wren, err;
  logic [23:0] key_q;
  logic [7:0] s_addr, s_wrdata;
  logic [1:0] phase;
  logic t_rdy, t_init_en, t_ksa_en, t_prga_en, t_s_wren, t_err;
  logic [23:0] t_key_q;
  logic [7:0] t_s_addr, t_s_wrdata;
  logic [1:0] t_phase;
  int tests = 0, fails = 0;
  int n_init = 0, n_ksa = 0, n_prga = 0, n_multi = 0, n_prga_t = 0;

  always #5 clk = ~clk;

  arc4_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .phase(phase), .err(err)
  );

  arc4_ctrl #(.TIMEOUT(16'd100)) dut_t (
    .clk(clk), .rst(rst), .en(en_t), .rdy(t_rdy), .key(key), .key_q(t_key_q),
    .init_en(t_init_en), .ksa_en(t_ksa_en), .prga_en(t_prga_en),
    .init_rdy(t_init_rdy), .ksa_rdy(t_ksa_rdy), .prga_rdy(t_prga_rdy),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(t_s_addr), .s_wrdata(t_s_wrdata), .s_wren(t_s_wren), .phase(t_phase), .err(t_err)
  );

  always @(posedge clk) begin
    n_init   <= n_init + int'(init_en);
    n_ksa    <= n_ksa + int'(ksa_en);
    n_prga   <= n_prga + int'(prga_en);
    n_prga_t <= n_prga_t + int'(t_prga_en);
    if (int'(init_en) + int'(ksa_en) + int'(prga_en) > 1) n_multi <= n_multi + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic en_of(input int p);
    return p == 1 ? init_en : p == 2 ? ksa_en : prga_en;
  endfunction

  task automatic set_rdy(input int p, input logic v);
    if (p == 1) init_rdy = v;
    else if (p == 2) ksa_rdy = v;
    else prga_rdy = v;
  endtask

  task automatic start_phase(input int p);
    int c = 0;
    tick;
    while (!en_of(p) && c < 8) begin
      tick;
      c++;
    end
    chk($sformatf("en_pulse_p%0d", p), 32'(en_of(p)), 32'd1);
    chk($sformatf("phase_at_en_p%0d", p), 32'(phase), 32'(p));
  endtask

  // sub-block keeps rdy high in the guard cycle, then drops it for len cycles
  task automatic hold_phase(input int p, input int len);
    tick;
    chk($sformatf("guard_p%0d", p), 32'(phase), 32'(p));
    set_rdy(p, 1'b0);
    repeat (len) tick;
    chk($sformatf("busy_p%0d", p), 32'(phase), 32'(p));
    set_rdy(p, 1'b1);
    tick;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_t = 1'b0; key = '0;
    {init_rdy, ksa_rdy, prga_rdy, t_init_rdy, t_ksa_rdy, t_prga_rdy} = '1;
    init_addr = 8'h11; init_wrdata = 8'h22; init_wren = 1'b1;
    ksa_addr = '0; ksa_wrdata = '0; ksa_wren = 1'b0;
    prga_addr = 8'h77; prga_wrdata = 8'h88; prga_wren = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_key_q", 32'(key_q), 32'd0);
    chk("idle_s_addr", 32'(s_addr), 32'd0);
    chk("idle_s_wren", 32'(s_wren), 32'd0);

    key = 24'h00033C; en = 1'b1;
    tick;
    en = 1'b0;
    chk("go_rdy", 32'(rdy), 32'd0);
    chk("go_key_q", 32'(key_q), 32'h00033C);
    chk("init_route_addr", 32'(s_addr), 32'h11);
    chk("init_route_wren", 32'(s_wren), 32'd1);
    start_phase(1);
    hold_phase(1, 255);
    chk("init_done_phase", 32'(phase), 32'd2);
    start_phase(2);
    ksa_addr = 8'h5A; ksa_wrdata = 8'hC3; ksa_wren = 1'b1;
    #1;
    chk("arb_s_addr", 32'(s_addr), 32'h5A);
    chk("arb_s_wrdata", 32'(s_wrdata), 32'hC3);
    chk("arb_s_wren", 32'(s_wren), 32'd1);
    key = 24'hFFFFFF; en = 1'b1;
    tick;
    en = 1'b0;
    ksa_rdy = 1'b0;
    tick;
    chk("busy_en_key_q", 32'(key_q), 32'h00033C);
    chk("busy_en_phase", 32'(phase), 32'd2);
    chk("busy_en_no_init", 32'(n_init), 32'd1);
    prga_rdy = 1'b0;
    repeat (766) tick;
    ksa_rdy = 1'b1;
    tick;
    chk("ksa_done_phase", 32'(phase), 32'd3);
    repeat (20) tick;
    chk("stall_no_prga_en", 32'(n_prga), 32'd0);
    prga_rdy = 1'b1;
    tick;
    chk("stall_prga_en", 32'(prga_en), 32'd1);
    hold_phase(3, 10);
    chk("nom_rdy", 32'(rdy), 32'd1);
    chk("nom_phase", 32'(phase), 32'd0);
    chk("nom_err", 32'(err), 32'd0);
    chk("nom_key_q", 32'(key_q), 32'h00033C);
    chk("nom_cnt_init", 32'(n_init), 32'd1);
    chk("nom_cnt_ksa", 32'(n_ksa), 32'd1);
    chk("nom_cnt_prga", 32'(n_prga), 32'd1);
    chk("nom_one_hot", 32'(n_multi), 32'd0);

    en_t = 1'b1;
    tick;
    en_t = 1'b0;
    tick; tick; tick;
    chk("t_ksa_go", 32'(t_phase), 32'd2);
    tick;
    chk("t_ksa_en", 32'(t_ksa_en), 32'd1);
    t_ksa_rdy = 1'b0;
    repeat (99) tick;
    chk("t_before_phase", 32'(t_phase), 32'd2);
    chk("t_before_err", 32'(t_err), 32'd0);
    tick;
    chk("t_err", 32'(t_err), 32'd1);
    chk("t_phase", 32'(t_phase), 32'd0);
    chk("t_rdy", 32'(t_rdy), 32'd1);
    tick; tick;
    chk("t_err_held", 32'(t_err), 32'd1);
    chk("t_no_prga_en", 32'(n_prga_t), 32'd0);
    en_t = 1'b1;
    tick;
    en_t = 1'b0;
    chk("t_err_cleared", 32'(t_err), 32'd0);

    init_wren = 1'b1;
    en = 1'b1;
    tick;
    en = 1'b0;
    tick; tick;
    chk("rr_busy_wren", 32'(s_wren), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rr_rdy", 32'(rdy), 32'd1);
    chk("rr_phase", 32'(phase), 32'd0);
    chk("rr_s_wren", 32'(s_wren), 32'd0);
    tick; tick; tick;
    chk("rr_no_ksa_en", 32'(n_ksa), 32'd1);
    rst = 1'b1; en = 1'b1;
    tick;
    rst = 1'b0; en = 1'b0;
    tick;
    chk("rst_over_en", 32'(phase), 32'd0);
    chk("rst_over_en_rdy", 32'(rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
